// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//
// Loadable up-counter with a programmable step.  The counter can either wrap
// modulo 2^WIDTH or clamp at all-ones when an increment carries out.
//
// Per-edge request priority: clear > load > increment > hold.  Only the
// winning request has any effect in a given cycle.
//
// Parameters
//   WIDTH     : counter / data width in bits (>= 2)
//   STEP      : amount added per increment (1 .. 2^WIDTH-1)
//   SATURATE  : 0 = wrap on overflow, 1 = clamp at all-ones
//   RESET_VAL : value loaded by reset and by clear
//
// Ports
//   clk_i   : clock, all state updates on the rising edge
//   rst_n_i : asynchronous active-low reset
//   clr_i   : synchronous clear to RESET_VAL
//   load_i  : synchronous load of in_i
//   in_i    : load data
//   inc_i   : increment by STEP
//   out_o   : counter value, straight from the register
//   ovf_o   : one-cycle pulse, the last increment carried past all-ones
//   sat_o   : level, counter is being held at all-ones by saturation
//             (constant 0 when SATURATE = 0)
// -----------------------------------------------------------------------------
module prog_counter #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      STEP      = 1,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] out_o,
    output logic             ovf_o,
    output logic             sat_o
);

    // Step widened by one bit so the carry of out + STEP is visible.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;

    logic [WIDTH:0]   sum;
    logic             carry;

    assign sum   = {1'b0, out_q} + STEP_EXT;
    assign carry = sum[WIDTH];

    // Next-state selection.  ovf is a pulse, so it defaults low every cycle;
    // sat is a level and only changes when a request resolves it.
    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        sat_d = sat_q;

        if (clr_i) begin
            out_d = RESET_VAL;
            sat_d = 1'b0;
        end else if (load_i) begin
            // Loading all-ones is not a saturation event, so sat clears.
            out_d = in_i;
            sat_d = 1'b0;
        end else if (inc_i) begin
            if (carry) begin
                ovf_d = 1'b1;
                if (SATURATE) begin
                    // Also covers incrementing while already pinned at
                    // all-ones: the carry repeats, so ovf pulses again.
                    out_d = '1;
                    sat_d = 1'b1;
                end else begin
                    out_d = sum[WIDTH-1:0];
                    sat_d = 1'b0;
                end
            end else begin
                out_d = sum[WIDTH-1:0];
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q <= RESET_VAL;
            ovf_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            sat_q <= sat_d;
        end
    end

    assign out_o = out_q;
    assign ovf_o = ovf_q;
    assign sat_o = sat_q;

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 16, counter and data width in bits (>= 2).
REQ-002 Parameter STEP, default 1, increment amount per inc cycle (1 <= STEP <= 2^WIDTH-1).
REQ-003 Parameter SATURATE, default 0, 0 = wrap modulo 2^WIDTH on overflow, 1 = clamp at all-ones.
REQ-004 Parameter RESET_VAL, default 0, value loaded by reset and clear.
REQ-005 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-007 clr_i  input  1  synchronous clear request.
REQ-008 load_i  input  1  synchronous load request.
REQ-009 in_i  input  WIDTH  load data.
REQ-010 inc_i  input  1  increment request.
REQ-011 out_o  output  WIDTH  current counter value, driven directly from register.
REQ-012 ovf_o  output  1  registered one-cycle pulse, increment crossed 2^WIDTH-1.
REQ-013 sat_o  output  1  registered level, counter held at all-ones by saturation (SATURATE=1 only, else tied 0).

Function
REQ-014 Per-edge priority SHALL be: clr_i > load_i > inc_i > hold.
REQ-015 clr_i=1: out_o <= RESET_VAL next edge, ovf_o <= 0, sat_o <= 0.
REQ-016 load_i=1 (clr_i=0): out_o <= in_i next edge, ovf_o <= 0, sat_o <= 0; inc_i ignored that cycle.
REQ-017 inc_i=1 (clr_i=0, load_i=0): sum = out_o + STEP computed at WIDTH+1 bits.
REQ-018 No carry out of sum: out_o <= sum[WIDTH-1:0], ovf_o <= 0, sat_o <= 0.
REQ-019 Carry out, SATURATE=0: out_o <= sum[WIDTH-1:0] (wrap), ovf_o <= 1 for exactly one cycle.
REQ-020 Carry out, SATURATE=1: out_o <= all-ones, ovf_o <= 1 for one cycle, sat_o <= 1.
REQ-021 SATURATE=1, out_o already all-ones, inc_i=1: out_o holds, ovf_o <= 1, sat_o stays 1.
REQ-022 All requests low: out_o holds, ovf_o <= 0, sat_o holds.
REQ-023 Latency: every request takes effect on out_o at the first rising edge it is sampled; no combinational path from any input to any output.
REQ-024 Simultaneous clr_i/load_i/inc_i SHALL follow REQ-014 with no partial effect from lower-priority requests.
REQ-025 Load of all-ones with SATURATE=1 SHALL NOT set sat_o; sat_o only set by a saturating increment.

Reset
REQ-026 rst_n_i=0 SHALL immediately, without clock, force out_o = RESET_VAL, ovf_o = 0, sat_o = 0.
REQ-027 Outputs SHALL remain at reset values while rst_n_i=0 regardless of clr_i/load_i/inc_i.
REQ-028 Reset asserted mid-operation (including during an ovf_o pulse) SHALL clear state in the same cycle; first update after deassertion occurs at the first rising edge with rst_n_i=1.

Verification
REQ-029 Defaults; reset, then inc_i=1 for 4 cycles -> out_o 0x0000,0x0001,0x0002,0x0003,0x0004; ovf_o=0.
REQ-030 Defaults; load_i=1 in_i=0xFFFE, then inc_i=1 for 3 cycles -> out_o 0xFFFE,0xFFFF,0x0000,0x0001; ovf_o=1 only in cycle out_o=0x0000.
REQ-031 SATURATE=1, STEP=4; load 0xFFFA, inc 3 cycles -> out_o 0xFFFE,0xFFFF,0xFFFF; ovf_o pulses each saturating cycle; sat_o=1 from first 0xFFFF.
REQ-032 Defaults; clr_i=load_i=inc_i=1 with out_o=0x1234 -> out_o=0x0000; then load_i=inc_i=1 in_i=0xAAAA -> out_o=0xAAAA (not 0xAAAB).
REQ-033 RESET_VAL=0x0100; count to 0x0105, drop rst_n_i between clock edges -> out_o=0x0100 immediately; release, inc 1 cycle -> 0x0101.
REQ-034 WIDTH=8, STEP=3; load 0xFE, inc -> out_o=0x01, ovf_o=1; hold 2 cycles -> out_o=0x01, ovf_o=0.
